// File: rtl/lzc_pkg.sv
// Shared types and helpers for the leading-zero/one counter pipeline.
// Holds the scan mode encoding and the count-width function.
package lzc_pkg;

  typedef enum logic {
    LZC_ZEROS = 1'b0,
    LZC_ONES  = 1'b1
  } lzc_mode_t;

  function automatic int lzc_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/lzc_norm_pipe_if.sv
// Valid/ready bundle between producer, lzc_norm_pipe and consumer.
// The master side feeds words and consumes results; the slave is the block.
interface lzc_norm_pipe_if
  import lzc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = lzc_cnt_width(DATA_WIDTH)
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic [DATA_WIDTH-1:0] out_norm;
  logic                  out_zero;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_cnt, out_norm, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_cnt, out_norm, out_zero
  );
endinterface

// File: rtl/leading_zeros.sv
// Combinational leading-zero counter, MSB first.
// Returns WIDTH when the word holds no set bit.
module leading_zeros
  import lzc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = lzc_cnt_width(WIDTH)
) (
  input  logic [WIDTH-1:0]     i_data,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  // Later (higher) set bits override earlier ones, so the MSB-most wins.
  always_comb begin
    o_cnt = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_cnt = CNT_WIDTH'(WIDTH - 1 - i);
    end
  end
endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero/one counter with normalising shift.
// Stage 1 counts each half; stage 2 combines, shifts and flags.
module lzc_norm_pipe
  import lzc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = lzc_cnt_width(DATA_WIDTH)
) (
  input logic          clk,
  input logic          rst,
  lzc_norm_pipe_if.slave bus
);
  localparam int HI  = DATA_WIDTH - DATA_WIDTH / 2;
  localparam int LO  = DATA_WIDTH / 2;
  localparam int HCW = lzc_cnt_width(HI);
  localparam int LCW = lzc_cnt_width(LO);

  lzc_mode_t             w_mode;
  logic [DATA_WIDTH-1:0] w_op;
  logic [HCW-1:0]        w_hi_cnt;
  logic [LCW-1:0]        w_lo_cnt;
  logic                  w_s1_load;
  logic                  w_s2_load;
  logic [CNT_WIDTH-1:0]  w_cnt;

  logic                  r_s1_valid;
  logic [HCW-1:0]        r_hi_cnt;
  logic                  r_hi_all;
  logic [LCW-1:0]        r_lo_cnt;
  logic [DATA_WIDTH-1:0] r_s1_data;

  logic                  r_out_valid;
  logic [CNT_WIDTH-1:0]  r_out_cnt;
  logic [DATA_WIDTH-1:0] r_out_norm;
  logic                  r_out_zero;

  // Ones mode scans the inverted word; the shift still uses the original.
  assign w_mode = lzc_mode_t'(bus.in_mode);
  assign w_op   = (w_mode == LZC_ONES) ? ~bus.in_data : bus.in_data;

  leading_zeros #(.WIDTH(HI)) u_lz_hi (
    .i_data (w_op[DATA_WIDTH-1:LO]),
    .o_cnt  (w_hi_cnt)
  );

  leading_zeros #(.WIDTH(LO)) u_lz_lo (
    .i_data (w_op[LO-1:0]),
    .o_cnt  (w_lo_cnt)
  );

  assign w_s2_load = !r_out_valid || bus.out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign bus.in_ready = w_s1_load && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_hi_cnt   <= '0;
      r_hi_all   <= 1'b0;
      r_lo_cnt   <= '0;
      r_s1_data  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_hi_cnt  <= w_hi_cnt;
        r_hi_all  <= (w_hi_cnt == HCW'(HI));
        r_lo_cnt  <= w_lo_cnt;
        r_s1_data <= bus.in_data;
      end
    end
  end

  assign w_cnt = r_hi_all ? CNT_WIDTH'(HI) + CNT_WIDTH'(r_lo_cnt)
                          : CNT_WIDTH'(r_hi_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_cnt   <= '0;
      r_out_norm  <= '0;
      r_out_zero  <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_cnt  <= w_cnt;
        r_out_norm <= r_s1_data << w_cnt;
        r_out_zero <= (w_cnt == CNT_WIDTH'(DATA_WIDTH));
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_norm  = r_out_norm;
  assign bus.out_zero  = r_out_zero;
endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Self-checking bench for lzc_norm_pipe at DATA_WIDTH=10.
// Inputs change on the falling edge; transfers are judged before the rising edge.
module tb_lzc_norm_pipe;
  import lzc_pkg::*;

  localparam int DW = 10;
  localparam int CW = lzc_cnt_width(DW);

  typedef struct {
    int          cnt;
    logic [DW-1:0] norm;
    bit          zero;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  res_t exp_q[$];
  res_t got_q[$];

  lzc_norm_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  lzc_norm_pipe #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic res_t ref_model(input logic [DW-1:0] d, input bit m);
    res_t r;
    logic [DW-1:0] x;
    int n;
    n = DW;
    for (int i = DW - 1; i >= 0; i--) begin
      if (d[i] != m) begin
        n = DW - 1 - i;
        break;
      end
    end
    x = d;
    for (int i = 0; i < n; i++) x = {x[DW-2:0], 1'b0};
    r.cnt  = n;
    r.norm = x;
    r.zero = (n == DW);
    r.cyc  = 0;
    return r;
  endfunction

  // Drive one cycle and log any input/output transfer it produces.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit m,
                      input bit ordy, output bit acc);
    res_t r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_mode   = m;
    bus.out_ready = ordy;
    #1;
    acc = v && bus.in_ready;
    if (acc) begin
      r = ref_model(d, m);
      r.cyc = cyc;
      exp_q.push_back(r);
    end
    if (bus.out_valid && ordy) begin
      r.cnt  = int'(bus.out_cnt);
      r.norm = bus.out_norm;
      r.zero = bus.out_zero;
      r.cyc  = cyc;
      got_q.push_back(r);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 30) begin
      step(1'b0, '0, 1'b0, 1'b1, a);
      n++;
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL drain_timeout got=%0d want=%0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs in_ready=%b out_valid=%b want 0/0",
               bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.out_cnt !== '0 || bus.out_norm !== '0 || bus.out_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_out cnt=%0d norm=%h zero=%b want 0/000/0",
               bus.out_cnt, bus.out_norm, bus.out_zero);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready=%b want 1", bus.in_ready);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_directed();
    bit a;
    clear_q();
    step(1'b1, 10'h020, 1'b0, 1'b1, a);
    drain();
    checks++;
    if (got_q.size() < 1 || got_q[0].cnt != 4 || got_q[0].norm !== 10'h200
        || got_q[0].zero !== 1'b0) begin
      errors++;
      $display("FAIL dir_020 cnt=%0d norm=%h zero=%b want 4/200/0",
               got_q.size() ? got_q[0].cnt : -1,
               got_q.size() ? got_q[0].norm : 10'h0,
               got_q.size() ? got_q[0].zero : 1'b0);
    end
    checks++;
    if (got_q.size() < 1 || got_q[0].cyc - exp_q[0].cyc != 2) begin
      errors++;
      $display("FAIL latency got=%0d want=2",
               got_q.size() ? got_q[0].cyc - exp_q[0].cyc : -1);
    end

    clear_q();
    step(1'b1, 10'h000, 1'b0, 1'b1, a);
    step(1'b1, 10'h3FF, 1'b1, 1'b1, a);
    drain();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (got_q.size() < 2 || got_q[i].cnt != 10 || got_q[i].norm !== 10'h000
          || got_q[i].zero !== 1'b1) begin
        errors++;
        $display("FAIL dir_allbits[%0d] cnt=%0d zero=%b want 10/1", i,
                 got_q.size() > i ? got_q[i].cnt : -1,
                 got_q.size() > i ? got_q[i].zero : 1'b0);
      end
    end
    checks++;
    if (got_q.size() < 2 || got_q[1].cyc != got_q[0].cyc + 1) begin
      errors++;
      $display("FAIL dir_allbits_consec gap=%0d want 1",
               got_q.size() > 1 ? got_q[1].cyc - got_q[0].cyc : -1);
    end

    clear_q();
    step(1'b1, 10'h3B0, 1'b1, 1'b1, a);
    drain();
    checks++;
    if (got_q.size() < 1 || got_q[0].cnt != 3 || got_q[0].norm !== 10'h180
        || got_q[0].zero !== 1'b0) begin
      errors++;
      $display("FAIL dir_ones_3b0 cnt=%0d norm=%h want 3/180",
               got_q.size() ? got_q[0].cnt : -1,
               got_q.size() ? got_q[0].norm : 10'h0);
    end
  endtask

  task automatic test_walk();
    bit a;
    logic [DW-1:0] w;
    clear_q();
    w = 10'h200;
    for (int i = 0; i <= DW; i++) begin
      step(1'b1, w, 1'b0, 1'b1, a);
      w = w >> 1;
    end
    drain();
    for (int i = 0; i <= DW; i++) begin
      checks++;
      if (got_q.size() <= i || got_q[i].cnt != i
          || got_q[i].cyc != exp_q[0].cyc + 2 + i) begin
        errors++;
        $display("FAIL walk[%0d] cnt=%0d cyc=%0d want %0d/%0d", i,
                 got_q.size() > i ? got_q[i].cnt : -1,
                 got_q.size() > i ? got_q[i].cyc : -1,
                 i, exp_q[0].cyc + 2 + i);
      end
    end
  endtask

  task automatic test_stall();
    bit a;
    int k;
    int c;
    logic [DW-1:0] w;
    clear_q();
    k = 0;
    c = 0;
    while (k < 6 && c < 40) begin
      w = 10'h200 >> k;
      step(1'b1, w, 1'b0, (c >= 4), a);
      if (c == 2 || c == 3) begin
        checks++;
        if (a !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready c=%0d accepted=%b want 0", c, a);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_cnt !== CW'(0)
            || bus.out_norm !== 10'h200) begin
          errors++;
          $display("FAIL stall_hold c=%0d v=%b cnt=%0d norm=%h want 1/0/200",
                   c, bus.out_valid, bus.out_cnt, bus.out_norm);
        end
      end
      if (a) k++;
      c++;
    end
    drain();
    checks++;
    if (got_q.size() != 6) begin
      errors++;
      $display("FAIL stall_count got=%0d want=6", got_q.size());
    end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].cnt != i || got_q[i].norm !== 10'h200) begin
        errors++;
        $display("FAIL stall_order[%0d] cnt=%0d norm=%h want %0d/200",
                 i, got_q[i].cnt, got_q[i].norm, i);
      end
    end
  endtask

  task automatic test_random();
    bit a;
    logic [DW-1:0] d;
    int sh;
    clear_q();
    for (int i = 0; i < 300; i++) begin
      d = DW'($urandom);
      sh = $urandom_range(0, DW);
      d = d >> sh;
      if ($urandom_range(0, 1) == 1) d = ~d;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0, a);
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].cnt != exp_q[i].cnt || got_q[i].norm !== exp_q[i].norm
          || got_q[i].zero !== exp_q[i].zero) begin
        errors++;
        $display("FAIL rand[%0d] got=%0d/%h/%b want=%0d/%h/%b", i,
                 got_q[i].cnt, got_q[i].norm, got_q[i].zero,
                 exp_q[i].cnt, exp_q[i].norm, exp_q[i].zero);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit a;
    clear_q();
    step(1'b1, 10'h0F0, 1'b0, 1'b0, a);
    step(1'b1, 10'h3C1, 1'b1, 1'b0, a);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_full out_valid=%b want 1", bus.out_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0
        || bus.out_cnt !== '0) begin
      errors++;
      $display("FAIL rstmid_async v=%b rdy=%b cnt=%0d want 0/0/0",
               bus.out_valid, bus.in_ready, bus.out_cnt);
    end
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_ready in_ready=%b want 1", bus.in_ready);
    end
    clear_q();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, a);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_stale got=%0d want=0", got_q.size());
    end
    step(1'b1, 10'h040, 1'b0, 1'b1, a);
    drain();
    checks++;
    if (got_q.size() < 1 || got_q[0].cnt != 3 || got_q[0].norm !== 10'h200
        || got_q[0].cyc - exp_q[0].cyc != 2) begin
      errors++;
      $display("FAIL rstmid_next cnt=%0d norm=%h lat=%0d want 3/200/2",
               got_q.size() ? got_q[0].cnt : -1,
               got_q.size() ? got_q[0].norm : 10'h0,
               got_q.size() ? got_q[0].cyc - exp_q[0].cyc : -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_walk();
    test_stall();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lzc_norm_pipe.md
# lzc_norm_pipe

Pipelined, parametrised leading-zero/leading-one counter with normalising left shift and valid/ready flow control. It is the sequential successor to the combinational leading-zero counter. It sits in front of fixed/floating-point normalisation and priority-select logic. It accepts one word per cycle and returns the count, the normalised word and an all-zero/all-one flag two cycles later, with full backpressure.

## Interface
- DATA_WIDTH, 32, input word width (≥2, odd allowed)
- CNT_WIDTH, $clog2(DATA_WIDTH+1), count width; must hold the value DATA_WIDTH
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  input word present
- in_ready  output  1  block can accept this cycle
- in_data  input  DATA_WIDTH  word to scan, MSB first
- in_mode  input  1  0 = count leading zeros, 1 = count leading ones
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_cnt  output  CNT_WIDTH  leading-bit count, 0..DATA_WIDTH
- out_norm  output  DATA_WIDTH  in_data << out_cnt, zero-filled, truncated to DATA_WIDTH
- out_zero  output  1  word contained no terminating bit (out_cnt == DATA_WIDTH)

## Operation
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Split: HI = DATA_WIDTH − DATA_WIDTH/2 upper bits, LO = DATA_WIDTH/2 lower bits.
- Mode handling: in ones mode the scan operand is ~in_data, while the shift always uses the original in_data.
- Stage 1 registers:
  - s1_valid
  - hi_cnt, hi_all (upper half has no terminating bit)
  - lo_cnt
  - original data
- Stage 2 / output registers:
  - out_cnt = hi_all ? HI + lo_cnt : hi_cnt
  - out_norm = data << out_cnt
  - out_zero = (out_cnt == DATA_WIDTH)
- Advance rules:
  - s2 loads when !out_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = s1 loads, and is forced 0 while rst is high.
- Bubbles: an empty s1 advancing into s2 clears out_valid. No word is dropped, duplicated or reordered.
- Stability: out_cnt, out_norm and out_zero hold stable while out_valid && !out_ready.
- Mode is captured per word. Mixed-mode streams are legal.

## Timing
- Latency: an input transfer in cycle t gives out_valid in cycle t+2 when out_ready is held high.
- Throughput: 1 word/cycle sustained with no bubbles under continuous out_ready.
- Capacity: 2 words (s1 + s2). With out_ready low, in_ready falls once both stages are full.
- Simultaneous input and output transfer in the same cycle: both complete and the pipeline shifts.
- Reset values: out_valid=0, out_cnt=0, out_norm=0, out_zero=0, s1_valid=0, in_ready=0 during rst and 1 in the first cycle after release.
- Reset mid-operation: all in-flight words are discarded immediately (asynchronous). No partial result appears after release.
- Boundary values:
  - all-zero input in zeros mode: cnt=DATA_WIDTH, norm=0, zero=1
  - all-ones input in ones mode: cnt=DATA_WIDTH, norm=0, zero=1
  - MSB set in zeros mode: cnt=0, norm=data

## Structure
- Shared package lzc_pkg:
  - typedef lzc_mode_t enum {LZC_ZEROS, LZC_ONES}
  - function lzc_cnt_width(width) returning $clog2(width+1)
- Sub-module: the existing combinational leading_zeros, instantiated twice in stage 1 (HI and LO halves) on the mode-adjusted operand.
- The combine and shift logic stays in this module.

## Test plan
All cases use DATA_WIDTH=10.
- Zeros mode, in_data=0x020, out_ready=1 → at t+2: out_cnt=4, out_norm=0x200, out_zero=0.
- in_data=0x000 in zeros mode, then 0x3FF in ones mode → both give out_cnt=10, out_norm=0x000, out_zero=1, on consecutive cycles.
- Ones mode, in_data=0x3B0 → out_cnt=3, out_norm=0x180, out_zero=0.
- Walking one 0x200 >>1 per cycle for 11 cycles, out_ready=1 → out_cnt=0,1,…,9,10 on consecutive cycles, no bubbles.
- Stream walking-one words with out_ready low for 4 cycles → in_ready low from the 3rd held word, outputs stable while stalled. After release, every word is delivered once, in order.
- Assert rst while s1 and s2 are both valid → out_valid=0 immediately. After release: in_ready=1, no stale outputs, and the next word returns correct results at t+2.
